// File: rtl/cache_types.sv
// Shared types for the cache miss/replacement controller.
// Holds the controller state encoding, default geometry and the
// line-address width derivation used by cache_replace_ctrl.
package cache_types;

  localparam int unsigned DEF_WAYS        = 4;
  localparam int unsigned DEF_S_INDEX     = 4;
  localparam int unsigned DEF_TAG_WIDTH   = 23;
  localparam int unsigned DEF_OFFSET_BITS = 5;

  // Full byte address width of a line: {tag, set, offset}.
  function automatic int unsigned addr_width(input int unsigned tag_w,
                                             input int unsigned idx_w,
                                             input int unsigned off_w);
    return tag_w + idx_w + off_w;
  endfunction

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WRITEBACK,
    FILL,
    UPDATE
  } repl_state_t;

endpackage

// File: rtl/cache_replace_ctrl_way_select.sv
// way_select: combinational victim picker.
// When INVALID_FIRST is set, the lowest-index invalid way wins; otherwise
// (or when every way is valid) the PLRU candidate is used.
// Ports:
//   way_valid_i  - valid bits of the set
//   plru_evict_i - one-hot PLRU eviction candidate
//   victim_o     - one-hot selected victim
module way_select #(
  parameter int unsigned WAYS          = 4,
  parameter bit          INVALID_FIRST = 1'b0
) (
  input  logic [WAYS-1:0] way_valid_i,
  input  logic [WAYS-1:0] plru_evict_i,
  output logic [WAYS-1:0] victim_o
);

  logic [WAYS-1:0] invalid;
  logic [WAYS-1:0] lowest_invalid;

  assign invalid        = ~way_valid_i;
  // x & -x isolates the lowest set bit.
  assign lowest_invalid = invalid & (~invalid + WAYS'(1));
  assign victim_o       = (INVALID_FIRST && (|invalid)) ? lowest_invalid : plru_evict_i;

endmodule

// File: rtl/cache_replace_ctrl.sv
// cache_replace_ctrl: sequences miss handling (victim select, writeback,
// fill, PLRU commit) and arbitrates the PLRU write port between core hit
// updates and the miss-commit update.
// Optional feature: define REPLACE_INVALID_FIRST_EN to prefer invalid ways
// (lowest index first) over the PLRU candidate.
// Ports:
//   clk, rst                       - clock, synchronous active-high reset
//   miss_valid/set/tag, miss_ready - miss request handshake
//   hit_valid/set/way, hit_ready   - hit PLRU update request / grant
//   plru_set_addr/hit_vector/web   - PLRU array write port (web active-low)
//   plru_evict                     - PLRU candidate for plru_set_addr
//   way_valid, way_dirty           - state of miss_set (used in LOOKUP)
//   victim_tag                     - tag of victim_way (used in WRITEBACK)
//   victim_way                     - registered one-hot victim
//   mem_read/write/addr, mem_resp  - memory-side line request
//   fill_we                        - write filled line into victim_way
//   done                           - one-cycle pulse at miss completion
module cache_replace_ctrl
  import cache_types::*;
#(
  parameter int unsigned WAYS        = DEF_WAYS,
  parameter int unsigned S_INDEX     = DEF_S_INDEX,
  parameter int unsigned TAG_WIDTH   = DEF_TAG_WIDTH,
  parameter int unsigned OFFSET_BITS = DEF_OFFSET_BITS
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  miss_valid,
  input  logic [S_INDEX-1:0]                    miss_set,
  input  logic [TAG_WIDTH-1:0]                  miss_tag,
  output logic                                  miss_ready,
  input  logic                                  hit_valid,
  input  logic [S_INDEX-1:0]                    hit_set,
  input  logic [WAYS-1:0]                       hit_way,
  output logic                                  hit_ready,
  output logic [S_INDEX-1:0]                    plru_set_addr,
  output logic [WAYS-1:0]                       plru_hit_vector,
  output logic                                  plru_web,
  input  logic [WAYS-1:0]                       plru_evict,
  input  logic [WAYS-1:0]                       way_valid,
  input  logic [WAYS-1:0]                       way_dirty,
  input  logic [TAG_WIDTH-1:0]                  victim_tag,
  output logic [WAYS-1:0]                       victim_way,
  output logic                                  mem_read,
  output logic                                  mem_write,
  output logic [TAG_WIDTH+S_INDEX+OFFSET_BITS-1:0] mem_addr,
  input  logic                                  mem_resp,
  output logic                                  fill_we,
  output logic                                  done
);

  localparam int unsigned ADDR_WIDTH = addr_width(TAG_WIDTH, S_INDEX, OFFSET_BITS);

`ifdef REPLACE_INVALID_FIRST_EN
  localparam bit INVALID_FIRST = 1'b1;
`else
  localparam bit INVALID_FIRST = 1'b0;
`endif

  repl_state_t            state_q, state_d;
  logic [S_INDEX-1:0]     miss_set_q;
  logic [TAG_WIDTH-1:0]   miss_tag_q;
  logic [WAYS-1:0]        victim_way_q;
  logic                   miss_ready_q, hit_ready_q;
  logic                   mem_read_q, mem_write_q, done_q;
  logic [WAYS-1:0]        victim_sel;
  logic                   need_wb;
  logic                   hit_win;

  way_select #(
    .WAYS          (WAYS),
    .INVALID_FIRST (INVALID_FIRST)
  ) u_way_select (
    .way_valid_i  (way_valid),
    .plru_evict_i (plru_evict),
    .victim_o     (victim_sel)
  );

  // An invalid victim never writes back, whichever way was chosen.
  assign need_wb = |(victim_sel & way_valid & way_dirty);

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (miss_valid) state_d = LOOKUP;
      LOOKUP:    state_d = need_wb ? WRITEBACK : FILL;
      WRITEBACK: if (mem_resp) state_d = FILL;
      FILL:      if (mem_resp) state_d = UPDATE;
      UPDATE:    state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // State, miss context and Moore outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      miss_set_q   <= '0;
      miss_tag_q   <= '0;
      victim_way_q <= '0;
      miss_ready_q <= 1'b1;
      hit_ready_q  <= 1'b1;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      miss_ready_q <= (state_d == IDLE);
      hit_ready_q  <= (state_d inside {IDLE, WRITEBACK, FILL});
      mem_read_q   <= (state_d == FILL);
      mem_write_q  <= (state_d == WRITEBACK);
      done_q       <= (state_d == UPDATE);
      if (state_q == IDLE && miss_valid) begin
        miss_set_q <= miss_set;
        miss_tag_q <= miss_tag;
      end
      if (state_q == LOOKUP) victim_way_q <= victim_sel;
    end
  end

  // Hits own the PLRU port whenever the controller does not; reset blocks writes.
  assign hit_win = hit_valid && !rst && (state_q inside {IDLE, WRITEBACK, FILL});

  // PLRU port mux.
  always_comb begin
    plru_set_addr   = '0;
    plru_hit_vector = '0;
    plru_web        = 1'b1;
    case (state_q)
      LOOKUP: plru_set_addr = miss_set_q;
      UPDATE: begin
        plru_set_addr = miss_set_q;
        if (!rst) begin
          plru_hit_vector = victim_way_q;
          plru_web        = 1'b0;
        end
      end
      default: begin
        if (hit_win) begin
          plru_set_addr   = hit_set;
          plru_hit_vector = hit_way;
          plru_web        = 1'b0;
        end
      end
    endcase
  end

  // Line address; victim_tag is only meaningful once victim_way is registered.
  always_comb begin
    mem_addr = '0;
    case (state_q)
      WRITEBACK: mem_addr = ADDR_WIDTH'({victim_tag, miss_set_q, {OFFSET_BITS{1'b0}}});
      FILL:      mem_addr = ADDR_WIDTH'({miss_tag_q, miss_set_q, {OFFSET_BITS{1'b0}}});
      default:   mem_addr = '0;
    endcase
  end

  assign fill_we    = (state_q == FILL) && mem_resp && !rst;
  assign miss_ready = miss_ready_q;
  assign hit_ready  = hit_ready_q;
  assign victim_way = victim_way_q;
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign done       = done_q;

endmodule

// File: tb/tb_cache_replace_ctrl.sv
// Self-checking bench for cache_replace_ctrl (default geometry: 4 ways,
// 16 sets, 23-bit tag, 5-bit offset). Includes a small external PLRU
// array model: a write marks hit_vector MRU and the next candidate becomes
// hit_vector rotated left by one.
module tb_cache_replace_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_valid;
  logic [3:0]  miss_set;
  logic [22:0] miss_tag;
  logic        miss_ready;
  logic        hit_valid;
  logic [3:0]  hit_set;
  logic [3:0]  hit_way;
  logic        hit_ready;
  logic [3:0]  plru_set_addr;
  logic [3:0]  plru_hit_vector;
  logic        plru_web;
  logic [3:0]  plru_evict;
  logic [3:0]  way_valid;
  logic [3:0]  way_dirty;
  logic [22:0] victim_tag;
  logic [3:0]  victim_way;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic        mem_resp;
  logic        fill_we;
  logic        done;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  cache_replace_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .miss_valid      (miss_valid),
    .miss_set        (miss_set),
    .miss_tag        (miss_tag),
    .miss_ready      (miss_ready),
    .hit_valid       (hit_valid),
    .hit_set         (hit_set),
    .hit_way         (hit_way),
    .hit_ready       (hit_ready),
    .plru_set_addr   (plru_set_addr),
    .plru_hit_vector (plru_hit_vector),
    .plru_web        (plru_web),
    .plru_evict      (plru_evict),
    .way_valid       (way_valid),
    .way_dirty       (way_dirty),
    .victim_tag      (victim_tag),
    .victim_way      (victim_way),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_addr        (mem_addr),
    .mem_resp        (mem_resp),
    .fill_we         (fill_we),
    .done            (done)
  );

  // External PLRU array model with a bench preload port.
  logic [3:0] plru_mem [16];
  logic       pre_en;
  logic [3:0] pre_set;
  logic [3:0] pre_val;

  always @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < 16; s++) plru_mem[s] <= 4'b0001;
    end else if (pre_en) begin
      plru_mem[pre_set] <= pre_val;
    end else if (!plru_web) begin
      plru_mem[plru_set_addr] <= {plru_hit_vector[2:0], plru_hit_vector[3]};
    end
  end
  assign plru_evict = plru_mem[plru_set_addr];

  typedef struct {
    logic [3:0]  set;
    logic [22:0] tag;
    logic [3:0]  valid;
    logic [3:0]  dirty;
    logic [3:0]  evict;
    logic [22:0] vtag;
    int          wb_dly;
    int          fill_dly;
    logic [3:0]  exp_victim;
    logic        exp_wb;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    else
      n_pass++;
  endtask

  task automatic preload(input logic [3:0] s, input logic [3:0] v);
    @(negedge clk);
    pre_en = 1'b1; pre_set = s; pre_val = v;
    @(posedge clk);
    #1 pre_en = 1'b0;
  endtask

  // One complete miss transaction, checked cycle by cycle.
  task automatic run_miss(input vec_t v);
    logic [31:0] ea;
    preload(v.set, v.evict);
    @(negedge clk);
    miss_valid = 1'b1; miss_set = v.set; miss_tag = v.tag;
    way_valid = v.valid; way_dirty = v.dirty; victim_tag = v.vtag; mem_resp = 1'b0;
    #1 chk("idle_miss_ready", 64'(miss_ready), 64'd1);
    @(negedge clk);
    miss_valid = 1'b0;
    #1;
    chk("lookup_miss_ready", 64'(miss_ready), 64'd0);
    chk("lookup_hit_ready", 64'(hit_ready), 64'd0);
    chk("lookup_plru_set", 64'(plru_set_addr), 64'(v.set));
    chk("lookup_mem_rw", 64'({mem_read, mem_write}), 64'd0);
    if (v.exp_wb) begin
      ea = {v.vtag, v.set, 5'b0};
      for (int k = 0; k <= v.wb_dly; k++) begin
        @(negedge clk);
        mem_resp = (k == v.wb_dly);
        #1;
        if (k == 0) chk("wb_victim_way", 64'(victim_way), 64'(v.exp_victim));
        chk("wb_mem_write", 64'(mem_write), 64'd1);
        chk("wb_mem_read", 64'(mem_read), 64'd0);
        chk("wb_mem_addr", 64'(mem_addr), 64'(ea));
        chk("wb_fill_we", 64'(fill_we), 64'd0);
      end
    end
    ea = {v.tag, v.set, 5'b0};
    for (int k = 0; k <= v.fill_dly; k++) begin
      @(negedge clk);
      mem_resp = (k == v.fill_dly);
      #1;
      if (k == 0 && !v.exp_wb) chk("fill_victim_way", 64'(victim_way), 64'(v.exp_victim));
      chk("fill_mem_read", 64'(mem_read), 64'd1);
      chk("fill_mem_write", 64'(mem_write), 64'd0);
      chk("fill_mem_addr", 64'(mem_addr), 64'(ea));
      chk("fill_we", 64'(fill_we), 64'(k == v.fill_dly));
      chk("fill_plru_web", 64'(plru_web), 64'd1);
    end
    @(negedge clk);
    mem_resp = 1'b0;
    #1;
    chk("upd_done", 64'(done), 64'd1);
    chk("upd_plru_web", 64'(plru_web), 64'd0);
    chk("upd_hit_vector", 64'(plru_hit_vector), 64'(v.exp_victim));
    chk("upd_plru_set", 64'(plru_set_addr), 64'(v.set));
    chk("upd_mem_read", 64'(mem_read), 64'd0);
    chk("upd_hit_ready", 64'(hit_ready), 64'd0);
    @(negedge clk);
    #1;
    chk("post_done", 64'(done), 64'd0);
    chk("post_miss_ready", 64'(miss_ready), 64'd1);
    chk("post_plru_web", 64'(plru_web), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Vector table: set, tag, valid, dirty, evict, vtag, wb_dly, fill_dly, victim, wb.
    vecs[0] = '{4'd2,  23'h12345,  4'b1111, 4'b0000, 4'b0100, 23'h0,      0, 0, 4'b0100, 1'b0};
    vecs[1] = '{4'd3,  23'h00777,  4'b1111, 4'b0010, 4'b0010, 23'h1A,     4, 1, 4'b0010, 1'b1};
    vecs[2] = '{4'd5,  23'h2AAAA,  4'b1111, 4'b1011, 4'b0100, 23'h3,      0, 0, 4'b0100, 1'b0};
`ifdef REPLACE_INVALID_FIRST_EN
    vecs[3] = '{4'd7,  23'h0BEEF,  4'b1011, 4'b0101, 4'b0001, 23'h55,     0, 0, 4'b0100, 1'b0};
    vecs[5] = '{4'd0,  23'h00001,  4'b0000, 4'b0000, 4'b1000, 23'h9,      0, 0, 4'b0001, 1'b0};
`else
    vecs[3] = '{4'd7,  23'h0BEEF,  4'b1011, 4'b0101, 4'b0001, 23'h55,     1, 0, 4'b0001, 1'b1};
    vecs[5] = '{4'd0,  23'h00001,  4'b0000, 4'b0000, 4'b1000, 23'h9,      0, 0, 4'b1000, 1'b0};
`endif
    vecs[4] = '{4'd15, 23'h7FFFFF, 4'b1111, 4'b1000, 4'b1000, 23'h400000, 0, 2, 4'b1000, 1'b1};

    rst = 1'b1; miss_valid = 1'b0; miss_set = '0; miss_tag = '0;
    hit_valid = 1'b0; hit_set = '0; hit_way = '0;
    way_valid = '0; way_dirty = '0; victim_tag = '0; mem_resp = 1'b0;
    pre_en = 1'b0; pre_set = '0; pre_val = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_miss_ready", 64'(miss_ready), 64'd1);
    chk("rst_hit_ready", 64'(hit_ready), 64'd1);
    chk("rst_plru_web", 64'(plru_web), 64'd1);
    chk("rst_hit_vector", 64'(plru_hit_vector), 64'd0);
    chk("rst_plru_set", 64'(plru_set_addr), 64'd0);
    chk("rst_victim_way", 64'(victim_way), 64'd0);
    chk("rst_mem_rw", 64'({mem_read, mem_write}), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_fill_done", 64'({fill_we, done}), 64'd0);

    for (int i = 0; i < 6; i++) run_miss(vecs[i]);

    // Arbitration: hit held through a miss (clean, fill after one wait cycle).
    preload(4'd4, 4'b0001);
    @(negedge clk);
    miss_valid = 1'b1; miss_set = 4'd4; miss_tag = 23'h100;
    way_valid = 4'b1111; way_dirty = 4'b0000; mem_resp = 1'b0;
    @(negedge clk);                                   // LOOKUP
    miss_valid = 1'b0; hit_valid = 1'b1; hit_set = 4'd9; hit_way = 4'b0010;
    #1;
    chk("arb_lookup_hit_ready", 64'(hit_ready), 64'd0);
    chk("arb_lookup_plru_set", 64'(plru_set_addr), 64'd4);
    chk("arb_lookup_web", 64'(plru_web), 64'd1);
    @(negedge clk);                                   // FILL, first grant
    #1;
    chk("arb_fill_hit_ready", 64'(hit_ready), 64'd1);
    chk("arb_fill_web", 64'(plru_web), 64'd0);
    chk("arb_fill_plru_set", 64'(plru_set_addr), 64'd9);
    chk("arb_fill_hit_vector", 64'(plru_hit_vector), 64'b0010);
    chk("arb_fill_victim", 64'(victim_way), 64'b0001);
    @(negedge clk);                                   // FILL, response
    mem_resp = 1'b1;
    #1;
    chk("arb_fill2_hit_ready", 64'(hit_ready), 64'd1);
    chk("arb_fill2_fill_we", 64'(fill_we), 64'd1);
    @(negedge clk);                                   // UPDATE
    mem_resp = 1'b0;
    #1;
    chk("arb_upd_hit_ready", 64'(hit_ready), 64'd0);
    chk("arb_upd_plru_set", 64'(plru_set_addr), 64'd4);
    chk("arb_upd_hit_vector", 64'(plru_hit_vector), 64'b0001);
    chk("arb_upd_done", 64'(done), 64'd1);
    @(negedge clk);                                   // IDLE
    #1;
    chk("arb_idle_hit_ready", 64'(hit_ready), 64'd1);
    chk("arb_idle_plru_set", 64'(plru_set_addr), 64'd9);
    hit_valid = 1'b0;
    #1;
    chk("arb_nohit_web", 64'(plru_web), 64'd1);
    chk("arb_nohit_vector", 64'(plru_hit_vector), 64'd0);

    // Simultaneous hit and miss to the same set in IDLE.
    preload(4'd6, 4'b0001);
    @(negedge clk);
    miss_valid = 1'b1; miss_set = 4'd6; miss_tag = 23'h66;
    hit_valid = 1'b1; hit_set = 4'd6; hit_way = 4'b0001;
    way_valid = 4'b1111; way_dirty = 4'b0000; mem_resp = 1'b0;
    #1;
    chk("sim_miss_ready", 64'(miss_ready), 64'd1);
    chk("sim_hit_web", 64'(plru_web), 64'd0);
    chk("sim_hit_set", 64'(plru_set_addr), 64'd6);
    chk("sim_hit_vector", 64'(plru_hit_vector), 64'b0001);
    @(negedge clk);                                   // LOOKUP
    miss_valid = 1'b0; hit_valid = 1'b0;
    #1 chk("sim_lookup_evict", 64'(plru_evict), 64'b0010);
    @(negedge clk);                                   // FILL
    mem_resp = 1'b1;
    #1;
    chk("sim_victim_way", 64'(victim_way), 64'b0010);
    chk("sim_fill_we", 64'(fill_we), 64'd1);
    @(negedge clk);
    mem_resp = 1'b0;
    #1 chk("sim_done", 64'(done), 64'd1);

    // Reset during WRITEBACK.
    preload(4'd3, 4'b0010);
    @(negedge clk);
    miss_valid = 1'b1; miss_set = 4'd3; miss_tag = 23'h777;
    way_valid = 4'b1111; way_dirty = 4'b0010; victim_tag = 23'h1A; mem_resp = 1'b0;
    @(negedge clk);                                   // LOOKUP
    miss_valid = 1'b0;
    @(negedge clk);                                   // WRITEBACK
    #1 chk("rwb_mem_write", 64'(mem_write), 64'd1);
    @(negedge clk);                                   // WRITEBACK, reset asserted
    rst = 1'b1;
    #1 chk("rwb_rst_fill_we", 64'(fill_we), 64'd0);
    @(negedge clk);
    rst = 1'b0; mem_resp = 1'b1;
    #1;
    chk("rwb_mem_write_drop", 64'(mem_write), 64'd0);
    chk("rwb_mem_read", 64'(mem_read), 64'd0);
    chk("rwb_miss_ready", 64'(miss_ready), 64'd1);
    chk("rwb_hit_ready", 64'(hit_ready), 64'd1);
    chk("rwb_victim_way", 64'(victim_way), 64'd0);
    chk("rwb_fill_we", 64'(fill_we), 64'd0);
    chk("rwb_done", 64'(done), 64'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk("rwb_idle_rw", 64'({mem_read, mem_write}), 64'd0);
      chk("rwb_idle_done_fill", 64'({done, fill_we}), 64'd0);
      chk("rwb_idle_web", 64'(plru_web), 64'd1);
    end
    mem_resp = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cache_replace_ctrl.md
# cache_replace_ctrl

Sequences cache miss handling around the per-set PLRU replacement array. It selects a victim way, writes back a dirty victim, fills the line from memory and commits the PLRU update. It also arbitrates the single PLRU write port between core hit updates and its own miss-commit update. It sits between the cache datapath (tag/valid/dirty arrays, PLRU array) and the memory-side port.

## Interface
Parameters:
- WAYS, 4, associativity; power of two, ≥2
- S_INDEX, 4, set index width (16 sets)
- TAG_WIDTH, 23, tag width
- OFFSET_BITS, 5, line offset width; ADDR_WIDTH = TAG_WIDTH+S_INDEX+OFFSET_BITS

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous and active-high
- miss_valid  in  1  core reports a miss
- miss_set  in  S_INDEX  set of the missing access
- miss_tag  in  TAG_WIDTH  tag of the missing access
- miss_ready  out  1  controller accepts a miss
- hit_valid  in  1  core reports a hit needing PLRU update
- hit_set  in  S_INDEX  set of the hit
- hit_way  in  WAYS  one-hot hit way
- hit_ready  out  1  hit update granted this cycle
- plru_set_addr  out  S_INDEX  PLRU array set address
- plru_hit_vector  out  WAYS  one-hot way to mark MRU
- plru_web  out  1  PLRU write enable, active-low; drives the PLRU block's evict_update
- plru_evict  in  WAYS  one-hot PLRU candidate for plru_set_addr
- way_valid  in  WAYS  valid bits of miss_set (array output, valid in LOOKUP)
- way_dirty  in  WAYS  dirty bits of miss_set (valid in LOOKUP)
- victim_tag  in  TAG_WIDTH  tag of the selected victim (valid in WRITEBACK)
- victim_way  out  WAYS  registered one-hot victim, drives tag-array way select
- mem_read  out  1  line fill request
- mem_write  out  1  line writeback request
- mem_addr  out  ADDR_WIDTH  line address, offset bits zero
- mem_resp  in  1  memory transaction complete
- fill_we  out  1  write filled line/tag/valid into victim_way; clear dirty
- done  out  1  one-cycle pulse: miss fully handled

## Operation
- States: IDLE, LOOKUP, WRITEBACK, FILL, UPDATE.
- IDLE: miss_ready=1. On miss_valid, latch miss_set/miss_tag and go to LOOKUP.
- LOOKUP: plru_set_addr=miss_set. Victim is selected and registered into victim_way. The next state is WRITEBACK if the victim is valid and dirty, else FILL.
- WRITEBACK: mem_write=1, mem_addr={victim_tag, miss_set, 0}. Hold until mem_resp, then go to FILL.
- FILL: mem_read=1, mem_addr={miss_tag, miss_set, 0}. In the mem_resp cycle, fill_we=1, then go to UPDATE.
- UPDATE: plru_set_addr=miss_set, plru_hit_vector=victim_way, plru_web=0, done=1. Next state is IDLE.
- Hit arbitration:
  - hit_ready=1 in IDLE, WRITEBACK and FILL. In those states the PLRU port carries hit_set/hit_way with plru_web=0 when hit_valid is high.
  - hit_ready=0 in LOOKUP and UPDATE, where the controller owns the port. The core holds hit_valid until granted.
- Simultaneous hit_valid and miss_valid in IDLE: both are accepted. The hit write lands at that edge; LOOKUP reads the updated PLRU state.
- When no write is active, plru_web=1 and plru_hit_vector=0.
- mem_resp is ignored in IDLE, LOOKUP and UPDATE.
- mem_read and mem_write are never high together.

## Timing
- Reset values: state IDLE, miss_ready=1, hit_ready=1, plru_web=1, plru_hit_vector=0, plru_set_addr=0, victim_way=0, mem_read=0, mem_write=0, mem_addr=0, fill_we=0, done=0.
- A miss is accepted at edge 0. LOOKUP runs in cycle 1. The request is first asserted in cycle 2.
- Clean victim with same-cycle mem_resp: done in cycle 3, and miss_ready is high again in cycle 4.
- Each memory request stays asserted, with a stable address, through the mem_resp cycle. It deasserts on the following cycle.
- Writeback adds at least 1 cycle: FILL starts the cycle after the writeback mem_resp.
- rst asserted mid-operation: the next edge returns to IDLE and drops mem_read/mem_write. No done or PLRU write is issued. The memory side is reset concurrently.

## Configuration
- REPLACE_INVALID_FIRST_EN defined: an invalid way, lowest index first, is chosen over plru_evict. An invalid victim never writes back.
- REPLACE_INVALID_FIRST_EN undefined: the victim is always plru_evict, and way_valid only gates writeback (valid&&dirty).

## Structure
- The shared package cache_types holds `repl_state_t` (the five states) and the ADDR_WIDTH-derivation constants.
- One sub-module, `way_select`, is combinational: it picks the lowest-index one-hot of ~way_valid, or else plru_evict.
- PLRU storage stays external. This block drives only its port.

## Test plan
- Clean miss: WAYS=4, all valid, clean, plru_evict=0100, mem_resp in the first request cycle. Required: mem_read only, victim_way=0100, fill_we in cycle 2, done in cycle 3, plru_hit_vector=0100.
- Dirty miss: victim way 1 dirty, victim_tag=0x1A, miss_set=3, mem_resp delayed 4 cycles. Required: mem_write with mem_addr={0x1A,3,0} held 5 cycles, then mem_read; done follows.
- Invalid-first: way_valid=1011 with the macro defined. Required: victim_way=0100 and no writeback. With the macro undefined, victim_way equals plru_evict.
- Arbitration: hit_valid held through a miss. Required: hit_ready=0 in LOOKUP and UPDATE only, and the hit is written in the first granted cycle.
- Simultaneous hit and miss in IDLE to the same set: the hit is written at edge 0, and LOOKUP uses the updated plru_evict.
- Reset during WRITEBACK: mem_write drops the next cycle, the state is IDLE, and no done or fill_we is seen.
